hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_AW, default 3: register-address width in bits; legal range is 3..5.
REQ-002 Parameter LOAD_BUBBLES, default 1: number of bubbles for a load-use hazard when forwarding is enabled; legal range is 1..3.
REQ-003 Parameter STAT_W, default 16: width of the stall statistics counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port forward_en, input, 1: 1 enables forwarding; 0 resolves every RAW hazard by stalling.
REQ-007 Port rs_id / rt_id, input, REG_AW each: source registers of the instruction in ID.
REQ-008 Port use_rs_id / use_rt_id, input, 1 each: the ID instruction actually reads rs / rt.
REQ-009 Port rs_ex / rt_ex, input, REG_AW each: source registers of the instruction in EX.
REQ-010 Port reg_write_ex, mem_read_ex, input, 1 each; dst_ex, input, REG_AW: describe the EX producer.
REQ-011 Port reg_write_m, input, 1; dst_m, input, REG_AW: describe the MEM producer.
REQ-012 Port reg_write_wb, input, 1; dst_wb, input, REG_AW: describe the WB producer.
REQ-013 Port forwardA / forwardB, output, 2 each: EX operand select, encoded as 00 register file, 01 WB, 10 MEM.
REQ-014 Port stall_if / stall_id, output, 1 each: hold PC / hold the IF/ID register.
REQ-015 Port flush_ex, output, 1: insert a bubble into ID/EX.
REQ-016 Port busy, output, 1: the FSM is in STALL.
REQ-017 Port stall_cycles, output, STAT_W: count of stalled cycles.

Function
REQ-018 The forwarding select logic SHALL be combinational.
REQ-019 forwardA SHALL be 10 when forward_en & reg_write_m & dst_m!=0 & dst_m==rs_ex.
REQ-020 Otherwise, forwardA SHALL be 01 when forward_en & reg_write_wb & dst_wb!=0 & dst_wb==rs_ex; otherwise it SHALL be 00.
REQ-021 forwardB SHALL follow the same rules using rt_ex.
REQ-022 MEM SHALL always win over WB when both match.
REQ-023 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-024 A hazard SHALL exist for ID source s when use_s_id & s!=0 and one of the following holds:
  - (a) forward_en=1: mem_read_ex & reg_write_ex & dst_ex==s. Required bubbles = LOAD_BUBBLES.
  - (b) forward_en=0: reg_write_ex & dst_ex==s. Required bubbles = 2.
  - (c) forward_en=0: reg_write_m & dst_m==s. Required bubbles = 1.
  - The WB producer never causes a hazard, because the register file writes before it reads.
REQ-025 When rs and rt both hit, the required bubble count SHALL be the maximum of the individual counts.
REQ-026 The FSM SHALL have two states, IDLE and STALL, and a bubble counter cnt.
REQ-027 In IDLE with a hazard: stall_if = stall_id = flush_ex = 1 in the same cycle.
  - If the required count is 1, the FSM stays in IDLE.
  - Otherwise, it moves to STALL with cnt = required-1.
REQ-028 In STALL: stall_if = stall_id = flush_ex = 1 and busy = 1, and hazard detection is masked.
  - cnt decrements each cycle.
  - When cnt==1, the FSM returns to IDLE on the next edge.
REQ-029 After stalling, a new hazard against a younger producer SHALL be detected normally.
REQ-030 A forward_en change SHALL take effect in the same cycle for forwarding and for detection in IDLE. It SHALL NOT alter a STALL already in progress.
REQ-031 stall_cycles SHALL increment on every cycle where stall_id=1 and SHALL saturate at all-ones.
REQ-032 The total stall length for one hazard SHALL equal exactly its required bubble count, with no extra cycle on entry or exit.

Reset
REQ-033 When rst=1 at a rising edge: state = IDLE, cnt = 0, stall_cycles = 0.
REQ-034 While in IDLE after reset, busy = 0.
REQ-035 Reset asserted mid-STALL SHALL abort the stall. From the following cycle, outputs reflect only the current combinational inputs.
REQ-036 While rst=1, stall_if, stall_id and flush_ex SHALL be forced to 0.

Structure
REQ-037 A shared package SHALL hold:
  - the forward-select constants FWD_NONE=00, FWD_WB=01, FWD_MEM=10;
  - the state enum {IDLE, STALL};
  - the bubble-count width constant (2 bits).
REQ-038 One sub-module, fwd_sel, SHALL compute a single operand select from one source address and the MEM/WB producer fields. It SHALL be instantiated twice, once for operand A and once for operand B.

Verification
REQ-039 Forwarding priority: forward_en=1, reg_write_m=1, dst_m=3, reg_write_wb=1, dst_wb=3, rs_ex=3, rt_ex=0 -> forwardA=10, forwardB=00.
REQ-040 Load-use: LOAD_BUBBLES=1, forward_en=1, mem_read_ex=1, reg_write_ex=1, dst_ex=5, rs_id=5, use_rs_id=1 -> exactly 1 cycle of stall_if=stall_id=flush_ex=1, busy=0, stall_cycles=1.
  - Repeat with LOAD_BUBBLES=3 -> 3 stall cycles, with busy=1 on cycles 2 and 3.
REQ-041 No forwarding: forward_en=0, reg_write_ex=1, dst_ex=2, rt_id=2, use_rt_id=1 -> 2 stall cycles and forwardA=forwardB=00 throughout.
  - With the producer in MEM instead -> 1 stall cycle.
REQ-042 Register 0 and unused operands: dst_ex=0, or use_rs_id=0 with a matching rs_id -> no stall and no forwarding.
REQ-043 Reset mid-stall: LOAD_BUBBLES=3, rst pulsed in the 2nd stall cycle -> state=IDLE, busy=0, stall_cycles=0 on the next cycle.
REQ-044 Saturation: STAT_W=4 with 20 stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard / forwarding unit.
//   FWD_*      : EX operand select encodings (register file, WB, MEM)
//   BUB_W      : width of the bubble counter
//   state_e    : stall FSM states
//   bub_max    : larger of two bubble counts
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int unsigned BUB_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    function automatic logic [BUB_W-1:0] bub_max(input logic [BUB_W-1:0] a,
                                                 input logic [BUB_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// fwd_sel: operand select for one EX source register.
//   fwd_en_i              : forwarding enabled
//   src_i                 : EX source register address
//   reg_write_m_i/dst_m_i : MEM-stage producer
//   reg_write_wb_i/dst_wb_i : WB-stage producer
//   sel_o                 : FWD_MEM, FWD_WB or FWD_NONE (MEM has priority)
module fwd_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic              fwd_en_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] dst_m_i,
    input  logic              reg_write_wb_i,
    input  logic [REG_AW-1:0] dst_wb_i,
    output logic [1:0]        sel_o
);

    // src != 0 together with dst == src implies dst != 0, so register 0
    // is excluded with a single test.
    always_comb begin
        sel_o = FWD_NONE;
        if (fwd_en_i && (src_i != '0)) begin
            if (reg_write_m_i && (dst_m_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (reg_write_wb_i && (dst_wb_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding plus RAW-hazard stall control.
//   clk, rst                 : clock, synchronous active-high reset
//   forward_en               : 1 = forward, 0 = resolve every RAW hazard by stalling
//   rs_id/rt_id, use_*_id    : ID-stage sources and whether they are read
//   rs_ex/rt_ex              : EX-stage sources (forwarding)
//   reg_write_ex/mem_read_ex/dst_ex : EX producer
//   reg_write_m/dst_m        : MEM producer
//   reg_write_wb/dst_wb      : WB producer
//   forwardA/forwardB        : EX operand selects
//   stall_if/stall_id/flush_ex : hold PC, hold IF/ID, bubble into ID/EX
//   busy                     : FSM in STALL
//   stall_cycles             : saturating count of stalled cycles
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic [REG_AW-1:0] dst_ex,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] dst_m,
    input  logic              reg_write_wb,
    input  logic [REG_AW-1:0] dst_wb,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              busy,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam logic [BUB_W-1:0] LOAD_BUB = BUB_W'(LOAD_BUBBLES);

    state_e            state_q, state_d;
    logic [BUB_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [BUB_W-1:0]  need_rs, need_rt, need;
    logic              stall;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .fwd_en_i       (forward_en),
        .src_i          (rs_ex),
        .reg_write_m_i  (reg_write_m),
        .dst_m_i        (dst_m),
        .reg_write_wb_i (reg_write_wb),
        .dst_wb_i       (dst_wb),
        .sel_o          (forwardA)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .fwd_en_i       (forward_en),
        .src_i          (rt_ex),
        .reg_write_m_i  (reg_write_m),
        .dst_m_i        (dst_m),
        .reg_write_wb_i (reg_write_wb),
        .dst_wb_i       (dst_wb),
        .sel_o          (forwardB)
    );

    // ------------------------------------------------------------------
    // Hazard detection: bubbles needed by one ID source. The WB producer
    // is ignored because the register file writes before it is read.
    // ------------------------------------------------------------------
    function automatic logic [BUB_W-1:0] src_need(
        input logic              use_s,
        input logic [REG_AW-1:0] s,
        input logic              fwd_en,
        input logic              rw_ex,
        input logic              mr_ex,
        input logic [REG_AW-1:0] d_ex,
        input logic              rw_m,
        input logic [REG_AW-1:0] d_m
    );
        logic [BUB_W-1:0] n;
        n = '0;
        if (use_s && (s != '0)) begin
            if (fwd_en) begin
                if (mr_ex && rw_ex && (d_ex == s)) begin
                    n = LOAD_BUB;
                end
            end else if (rw_ex && (d_ex == s)) begin
                n = BUB_W'(2);
            end else if (rw_m && (d_m == s)) begin
                n = BUB_W'(1);
            end
        end
        return n;
    endfunction

    always_comb begin
        need_rs = src_need(use_rs_id, rs_id, forward_en, reg_write_ex,
                           mem_read_ex, dst_ex, reg_write_m, dst_m);
        need_rt = src_need(use_rt_id, rt_id, forward_en, reg_write_ex,
                           mem_read_ex, dst_ex, reg_write_m, dst_m);
        need    = bub_max(need_rs, need_rt);
    end

    // ------------------------------------------------------------------
    // Stall FSM. The first bubble is issued from IDLE in the hazard cycle
    // itself, so STALL only covers the remaining need-1 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (need != '0) begin
                    stall = 1'b1;
                    if (need != BUB_W'(1)) begin
                        state_d = STALL;
                        cnt_d   = need - BUB_W'(1);
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                cnt_d = cnt_q - BUB_W'(1);
                if (cnt_q == BUB_W'(1)) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_if     = stall;
    assign stall_id     = stall;
    assign flush_ex     = stall;
    assign busy         = (state_q == STALL);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit. Two instances share the same
// inputs: one with LOAD_BUBBLES=1/STAT_W=16, one with LOAD_BUBBLES=3/STAT_W=4.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic [2:0] rs_id, rt_id, rs_ex, rt_ex, dst_ex, dst_m, dst_wb;
    logic       use_rs_id, use_rt_id;
    logic       reg_write_ex, mem_read_ex, reg_write_m, reg_write_wb;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic        sif_a, sid_a, fl_a, busy_a;
    logic        sif_b, sid_b, fl_b, busy_b;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(3), .LOAD_BUBBLES(1), .STAT_W(16)) dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .dst_ex(dst_ex),
        .reg_write_m(reg_write_m), .dst_m(dst_m),
        .reg_write_wb(reg_write_wb), .dst_wb(dst_wb),
        .forwardA(fa_a), .forwardB(fb_a),
        .stall_if(sif_a), .stall_id(sid_a), .flush_ex(fl_a),
        .busy(busy_a), .stall_cycles(sc_a)
    );

    hazard_forward_unit #(.REG_AW(3), .LOAD_BUBBLES(3), .STAT_W(4)) dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .dst_ex(dst_ex),
        .reg_write_m(reg_write_m), .dst_m(dst_m),
        .reg_write_wb(reg_write_wb), .dst_wb(dst_wb),
        .forwardA(fa_b), .forwardB(fb_b),
        .stall_if(sif_b), .stall_id(sid_b), .flush_ex(fl_b),
        .busy(busy_b), .stall_cycles(sc_b)
    );

    typedef struct {
        bit rst, fe, use_rs, use_rt, rw_ex, mr_ex, rw_m, rw_wb;
        int rs_id, rt_id, rs_ex, rt_ex, dst_ex, dst_m, dst_wb;
    } vec_t;

    typedef struct {
        int fa, fb;
        int stall [2];
        int busy  [2];
        int cnt   [2];
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state per instance: STALL-state cycles still owed and stat count.
    int pend [2] = '{0, 0};
    int scnt [2] = '{0, 0};
    int lbub [2] = '{1, 3};
    int smax [2] = '{65535, 15};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int fwd_ref(input vec_t v, input int src);
        if (!v.fe || src == 0) return 0;
        if (v.rw_m && v.dst_m == src) return 2;
        if (v.rw_wb && v.dst_wb == src) return 1;
        return 0;
    endfunction

    function automatic int need_ref(input vec_t v, input bit use_s, input int s, input int lb);
        int n;
        n = 0;
        if (!use_s || s == 0) return 0;
        if (v.fe) begin
            if (v.mr_ex && v.rw_ex && v.dst_ex == s) n = lb;
        end else begin
            if (v.rw_m && v.dst_m == s) n = 1;
            if (v.rw_ex && v.dst_ex == s) n = 2;
        end
        return n;
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic apply(input vec_t v);
        exp_t e;
        int   nr, nt, need, st;
        rst          = v.rst;
        forward_en   = v.fe;
        use_rs_id    = v.use_rs;
        use_rt_id    = v.use_rt;
        reg_write_ex = v.rw_ex;
        mem_read_ex  = v.mr_ex;
        reg_write_m  = v.rw_m;
        reg_write_wb = v.rw_wb;
        rs_id  = 3'(v.rs_id);
        rt_id  = 3'(v.rt_id);
        rs_ex  = 3'(v.rs_ex);
        rt_ex  = 3'(v.rt_ex);
        dst_ex = 3'(v.dst_ex);
        dst_m  = 3'(v.dst_m);
        dst_wb = 3'(v.dst_wb);
        e.fa = fwd_ref(v, v.rs_ex);
        e.fb = fwd_ref(v, v.rt_ex);
        for (int k = 0; k < 2; k++) begin
            nr   = need_ref(v, v.use_rs, v.rs_id, lbub[k]);
            nt   = need_ref(v, v.use_rt, v.rt_id, lbub[k]);
            need = (nr > nt) ? nr : nt;
            e.busy[k] = (pend[k] > 0) ? 1 : 0;
            st = (pend[k] > 0 || need > 0) ? 1 : 0;
            if (v.rst) st = 0;
            e.stall[k] = st;
            e.cnt[k]   = scnt[k];
            if (v.rst) begin
                pend[k] = 0;
                scnt[k] = 0;
            end else begin
                if (pend[k] > 0) pend[k] = pend[k] - 1;
                else if (need > 1) pend[k] = need - 1;
                if (st == 1 && scnt[k] < smax[k]) scnt[k] = scnt[k] + 1;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.rst    = ($urandom_range(0, 39) == 0);
        v.fe     = 1'($urandom_range(0, 1));
        v.use_rs = 1'($urandom_range(0, 1));
        v.use_rt = 1'($urandom_range(0, 1));
        v.rw_ex  = 1'($urandom_range(0, 1));
        v.mr_ex  = 1'($urandom_range(0, 1));
        v.rw_m   = 1'($urandom_range(0, 1));
        v.rw_wb  = 1'($urandom_range(0, 1));
        v.rs_id  = int'($urandom_range(0, 7));
        v.rt_id  = int'($urandom_range(0, 7));
        v.rs_ex  = int'($urandom_range(0, 7));
        v.rt_ex  = int'($urandom_range(0, 7));
        v.dst_ex = int'($urandom_range(0, 7));
        v.dst_m  = int'($urandom_range(0, 7));
        v.dst_wb = int'($urandom_range(0, 7));
        return v;
    endfunction

    // Monitor: every cycle is an output beat; compare away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("A.forwardA",     int'(fa_a),   e.fa);
                chk("A.forwardB",     int'(fb_a),   e.fb);
                chk("A.stall_if",     int'(sif_a),  e.stall[0]);
                chk("A.stall_id",     int'(sid_a),  e.stall[0]);
                chk("A.flush_ex",     int'(fl_a),   e.stall[0]);
                chk("A.busy",         int'(busy_a), e.busy[0]);
                chk("A.stall_cycles", int'(sc_a),   e.cnt[0]);
                chk("B.forwardA",     int'(fa_b),   e.fa);
                chk("B.forwardB",     int'(fb_b),   e.fb);
                chk("B.stall_if",     int'(sif_b),  e.stall[1]);
                chk("B.stall_id",     int'(sid_b),  e.stall[1]);
                chk("B.flush_ex",     int'(fl_b),   e.stall[1]);
                chk("B.busy",         int'(busy_b), e.busy[1]);
                chk("B.stall_cycles", int'(sc_b),   e.cnt[1]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v, ld, nf;
        v = idle_vec();
        v.rst = 1'b1;
        rst = 1'b1; forward_en = 1'b0;
        use_rs_id = 1'b0; use_rt_id = 1'b0;
        reg_write_ex = 1'b0; mem_read_ex = 1'b0; reg_write_m = 1'b0; reg_write_wb = 1'b0;
        rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0; dst_ex = '0; dst_m = '0; dst_wb = '0;
        @(posedge clk);
        #1;
        apply(v);                       // reset state observed
        apply(idle_vec());

        // MEM wins over WB; rt_ex = 0 never forwarded
        v = idle_vec();
        v.fe = 1; v.rw_m = 1; v.dst_m = 3; v.rw_wb = 1; v.dst_wb = 3; v.rs_ex = 3; v.rt_ex = 0;
        apply(v);
        v.rt_ex = 4; v.dst_wb = 4;
        apply(v);

        // load-use
        ld = idle_vec();
        ld.fe = 1; ld.mr_ex = 1; ld.rw_ex = 1; ld.dst_ex = 5; ld.rs_id = 5; ld.use_rs = 1;
        apply(ld);
        repeat (4) apply(idle_vec());

        // no forwarding: EX producer, then MEM producer
        nf = idle_vec();
        nf.fe = 0; nf.rw_ex = 1; nf.dst_ex = 2; nf.rt_id = 2; nf.use_rt = 1;
        nf.rs_ex = 2; nf.rt_ex = 2; nf.rw_m = 1; nf.dst_m = 2;
        apply(nf);
        repeat (3) apply(idle_vec());
        v = idle_vec();
        v.rw_m = 1; v.dst_m = 2; v.rt_id = 2; v.use_rt = 1;
        apply(v);
        repeat (3) apply(idle_vec());

        // register 0 and unused operand
        v = ld; v.dst_ex = 0; v.rs_id = 0;
        apply(v);
        v = ld; v.use_rs = 0;
        apply(v);
        v = nf; v.use_rt = 0;
        apply(v);
        apply(idle_vec());

        // reset in the second stall cycle
        apply(ld);
        v = idle_vec(); v.rst = 1;
        apply(v);
        repeat (2) apply(idle_vec());

        // saturation: hazard held for 20 cycles
        repeat (20) apply(nf);
        repeat (3) apply(idle_vec());

        // randomized
        repeat (3000) apply(rand_vec());
        repeat (4) apply(idle_vec());

        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
